// File: rtl/branch_pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: branch-mode and FSM encodings plus
// a small helper used by both the sequencer and its comparator.
package branch_pc_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BNE  = 3'b010,
        OP_BLT  = 3'b011,
        OP_BGE  = 3'b100,
        OP_BLTU = 3'b101,
        OP_J    = 3'b110,
        OP_JR   = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // Conditional branches are the ones that feed branch_count.
    function automatic logic is_cond_op(input br_op_e op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU);
    endfunction

endpackage

// File: rtl/branch_pc_sequencer_compare.sv
// Combinational branch resolution: maps (br_op, rs, rt) to a taken flag.
// Unconditional jumps always report taken; NONE never does.
module branch_compare
    import branch_pc_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              taken
);

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(br_op))
            OP_BEQ:  taken = (rs_data == rt_data);
            OP_BNE:  taken = (rs_data != rt_data);
            OP_BLT:  taken = ($signed(rs_data) <  $signed(rt_data));
            OP_BGE:  taken = ($signed(rs_data) >= $signed(rt_data));
            OP_BLTU: taken = (rs_data < rt_data);
            OP_J:    taken = 1'b1;
            OP_JR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program counter and branch resolution: drives the fetch address, squashes
// fetch after redirects, and counts retired/taken branches.
module branch_pc_sequencer
    import branch_pc_sequencer_pkg::*;
#(
    parameter int unsigned     DATA_W   = 32,
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              halt_req,
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [31:0]       imm,
    input  logic [25:0]       jtarget,
    output logic [PC_W-1:0]   pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam int unsigned STEP_SH = $clog2(PC_STEP);
    localparam int unsigned J_BITS  = 26 + STEP_SH;

    state_e            state;
    state_e            state_next;
    logic              taken;
    logic              retire;
    logic              flush_next;
    logic [PC_W-1:0]   seq;
    logic [PC_W-1:0]   imm_off;
    logic [PC_W-1:0]   br_target;
    logic [PC_W-1:0]   j_mask;
    logic [PC_W-1:0]   j_target;
    logic [PC_W-1:0]   jr_target;
    logic [PC_W-1:0]   pc_next;
    logic [CNT_W-1:0]  branch_next;
    logic [CNT_W-1:0]  taken_next;

    branch_compare #(
        .DATA_W(DATA_W)
    ) u_compare (
        .br_op  (br_op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .taken  (taken)
    );

    // All targets are formed in PC_W bits so wrap-around is modulo 2^PC_W.
    // The J field is scaled by PC_STEP and replaces the low J_BITS of seq.
    always_comb begin
        seq       = pc + PC_W'(PC_STEP);
        imm_off   = PC_W'($signed(imm)) * PC_W'(PC_STEP);
        br_target = seq + imm_off;
        j_mask    = (PC_W'(1) << J_BITS) - PC_W'(1);
        j_target  = (seq & ~j_mask) | (PC_W'(jtarget) << STEP_SH);
        jr_target = PC_W'(rs_data);
    end

    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        pc_next     = pc;
        flush_next  = 1'b0;
        branch_next = branch_count;
        taken_next  = taken_count;

        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    retire = 1'b1;
                    if (halt_req) state_next = ST_HALT;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_BOOT;
        endcase

        if (retire) begin
            case (br_op_e'(br_op))
                OP_NONE: pc_next = seq;
                OP_J:    pc_next = j_target;
                OP_JR:   pc_next = jr_target;
                default: pc_next = taken ? br_target : seq;
            endcase
            flush_next = taken;
            if (is_cond_op(br_op_e'(br_op)) && (branch_count != '1))
                branch_next = branch_count + CNT_W'(1);
            if (taken && (taken_count != '1))
                taken_next = taken_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            pc_valid     <= 1'b0;
            flush        <= 1'b0;
            halted       <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            pc_valid     <= (state_next == ST_RUN);
            flush        <= flush_next;
            halted       <= (state_next == ST_HALT);
            branch_count <= branch_next;
            taken_count  <= taken_next;
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: three configurations share one stimulus stream
// and are checked against a behavioural model, a directed table and hand sequences.
module tb_branch_pc_sequencer;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        halt_req;
    logic [2:0]  br_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [25:0] jtarget;

    logic [31:0] pc_o     [3];
    logic        valid_o  [3];
    logic        flush_o  [3];
    logic        halted_o [3];
    logic [15:0] bc_o     [2];
    logic [15:0] tc_o     [2];
    logic [1:0]  bc_c;
    logic [1:0]  tc_c;

    int unsigned total;
    int unsigned bad;

    branch_pc_sequencer #(.DATA_W(32), .PC_W(32), .PC_STEP(1), .RESET_PC(32'h0), .CNT_W(16)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .stall(stall), .halt_req(halt_req), .br_op(br_op),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .jtarget(jtarget),
        .pc(pc_o[0]), .pc_valid(valid_o[0]), .flush(flush_o[0]), .halted(halted_o[0]),
        .branch_count(bc_o[0]), .taken_count(tc_o[0]));

    branch_pc_sequencer #(.DATA_W(32), .PC_W(32), .PC_STEP(4), .RESET_PC(32'h0), .CNT_W(16)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .stall(stall), .halt_req(halt_req), .br_op(br_op),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .jtarget(jtarget),
        .pc(pc_o[1]), .pc_valid(valid_o[1]), .flush(flush_o[1]), .halted(halted_o[1]),
        .branch_count(bc_o[1]), .taken_count(tc_o[1]));

    branch_pc_sequencer #(.DATA_W(32), .PC_W(32), .PC_STEP(1), .RESET_PC(32'h0), .CNT_W(2)) u_dutc (
        .clock(clock), .reset_n(reset_n), .stall(stall), .halt_req(halt_req), .br_op(br_op),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .jtarget(jtarget),
        .pc(pc_o[2]), .pc_valid(valid_o[2]), .flush(flush_o[2]), .halted(halted_o[2]),
        .branch_count(bc_c), .taken_count(tc_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Architectural view of one sequencer instance.
    typedef struct {
        logic [31:0] pc;
        bit          valid;
        bit          flush;
        bit          halted;
        bit          boot;
        int unsigned bc;
        int unsigned tc;
    } mdl_t;

    mdl_t m [3];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] im;
        logic [25:0] jt;
        logic        st;
        logic [31:0] pc;
        logic        fl;
        int unsigned bc;
        int unsigned tc;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] im, input logic [25:0] jt, input logic st,
                                input logic [31:0] pc, input logic fl, input int unsigned bc,
                                input int unsigned tc);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.im = im; v.jt = jt; v.st = st;
        v.pc = pc; v.fl = fl; v.bc = bc; v.tc = tc;
        return v;
    endfunction

    function automatic mdl_t model_next(input mdl_t s, input int unsigned step, input int unsigned cmax);
        mdl_t n = s;
        longint unsigned seq;
        longint unsigned tgt;
        longint unsigned mask;
        int unsigned sh;
        bit tk;
        n.flush = 1'b0;
        if (!reset_n) begin
            n.pc = 32'h0; n.valid = 1'b0; n.halted = 1'b0; n.boot = 1'b1; n.bc = 0; n.tc = 0;
            return n;
        end
        if (s.boot) begin
            n.boot = 1'b0; n.valid = 1'b1;
            return n;
        end
        if (s.halted || stall) return n;
        seq = (longint'(s.pc) + longint'(step)) & 64'hFFFF_FFFF;
        case (br_op)
            3'd1: tk = (rs_data == rt_data);
            3'd2: tk = (rs_data != rt_data);
            3'd3: tk = (int'(rs_data) < int'(rt_data));
            3'd4: tk = (int'(rs_data) >= int'(rt_data));
            3'd5: tk = (rs_data < rt_data);
            3'd6, 3'd7: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        tgt = seq + longint'(longint'(int'(imm)) * longint'(step));
        sh = 0;
        while ((32'd1 << sh) < step) sh++;
        mask = (64'd1 << (26 + sh)) - 64'd1;
        case (br_op)
            3'd0: n.pc = 32'(seq);
            3'd6: n.pc = 32'((seq & ~mask) | (64'(jtarget) << sh));
            3'd7: n.pc = rs_data;
            default: n.pc = tk ? 32'(tgt) : 32'(seq);
        endcase
        if (br_op >= 3'd1 && br_op <= 3'd5 && s.bc < cmax) n.bc = s.bc + 1;
        if (tk && s.tc < cmax) n.tc = s.tc + 1;
        n.flush = tk;
        if (halt_req) begin
            n.halted = 1'b1; n.valid = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_bc(input int i);
        case (i)
            0: return 64'(bc_o[0]);
            1: return 64'(bc_o[1]);
            default: return 64'(bc_c);
        endcase
    endfunction

    function automatic logic [63:0] dut_tc(input int i);
        case (i)
            0: return 64'(tc_o[0]);
            1: return 64'(tc_o[1]);
            default: return 64'(tc_c);
        endcase
    endfunction

    task automatic cycle();
        m[0] = model_next(m[0], 1, 65535);
        m[1] = model_next(m[1], 4, 65535);
        m[2] = model_next(m[2], 1, 3);
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_pc[%0d]", i),     64'(pc_o[i]),     64'(m[i].pc));
            chk($sformatf("model_valid[%0d]", i),  64'(valid_o[i]),  64'(m[i].valid));
            chk($sformatf("model_flush[%0d]", i),  64'(flush_o[i]),  64'(m[i].flush));
            chk($sformatf("model_halted[%0d]", i), 64'(halted_o[i]), 64'(m[i].halted));
            chk($sformatf("model_bc[%0d]", i),     dut_bc(i),        64'(m[i].bc));
            chk($sformatf("model_tc[%0d]", i),     dut_tc(i),        64'(m[i].tc));
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] im, input logic [25:0] jt, input logic st,
                         input logic hr);
        br_op = op; rs_data = rs; rt_data = rt; imm = im; jtarget = jt; stall = st; halt_req = hr;
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) m[i] = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};

        // Hand-derived PC_STEP=1 trace, starting at pc=0 right after BOOT.
        tbl.push_back(mk(3'd0, 32'h0,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0001, 1'b0,  0,  0));
        tbl.push_back(mk(3'd0, 32'h0,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0002, 1'b0,  0,  0));
        tbl.push_back(mk(3'd0, 32'h0,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0003, 1'b0,  0,  0));
        tbl.push_back(mk(3'd7, 32'h5,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0005, 1'b1,  0,  1));
        tbl.push_back(mk(3'd1, 32'h7,        32'h7,        32'hFFFF_FFFD, 26'h0,      1'b0, 32'h0000_0003, 1'b1,  1,  2));
        tbl.push_back(mk(3'd7, 32'h5,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0005, 1'b1,  1,  3));
        tbl.push_back(mk(3'd1, 32'h7,        32'h8,        32'hFFFF_FFFD, 26'h0,      1'b0, 32'h0000_0006, 1'b0,  2,  3));
        tbl.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'h1,       32'd10,       26'h0,       1'b0, 32'h0000_0011, 1'b1,  3,  4));
        tbl.push_back(mk(3'd5, 32'hFFFF_FFFF, 32'h1,       32'd10,       26'h0,       1'b0, 32'h0000_0012, 1'b0,  4,  4));
        tbl.push_back(mk(3'd4, 32'h9,        32'h9,        32'd2,        26'h0,       1'b0, 32'h0000_0015, 1'b1,  5,  5));
        tbl.push_back(mk(3'd1, 32'h4,        32'h4,        32'd0,        26'h0,       1'b0, 32'h0000_0016, 1'b1,  6,  6));
        tbl.push_back(mk(3'd2, 32'h1,        32'h1,        32'd5,        26'h0,       1'b0, 32'h0000_0017, 1'b0,  7,  6));
        tbl.push_back(mk(3'd3, 32'h1,        32'hFFFF_FFFF, 32'd5,       26'h0,       1'b0, 32'h0000_0018, 1'b0,  8,  6));
        tbl.push_back(mk(3'd4, 32'h8000_0000, 32'h0,       32'd5,        26'h0,       1'b0, 32'h0000_0019, 1'b0,  9,  6));
        tbl.push_back(mk(3'd5, 32'h1,        32'hFFFF_FFFF, 32'd4,       26'h0,       1'b0, 32'h0000_001E, 1'b1, 10,  7));
        tbl.push_back(mk(3'd6, 32'h0,        32'h0,        32'h0,        26'h3FF_FFFF, 1'b0, 32'h03FF_FFFF, 1'b1, 10,  8));
        tbl.push_back(mk(3'd7, 32'hFFFF_FFFF, 32'h0,       32'h0,        26'h0,       1'b0, 32'hFFFF_FFFF, 1'b1, 10,  9));
        tbl.push_back(mk(3'd0, 32'h0,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0000, 1'b0, 10,  9));
        tbl.push_back(mk(3'd1, 32'h2,        32'h2,        32'hFFFF_FFFF, 26'h0,      1'b0, 32'h0000_0000, 1'b1, 11, 10));
        tbl.push_back(mk(3'd2, 32'h3,        32'h4,        32'hFFFF_FFFF, 26'h0,      1'b0, 32'h0000_0000, 1'b1, 12, 11));
        tbl.push_back(mk(3'd7, 32'h8400_0000, 32'h0,       32'h0,        26'h0,       1'b0, 32'h8400_0000, 1'b1, 12, 12));
        tbl.push_back(mk(3'd6, 32'h0,        32'h0,        32'h0,        26'h10,      1'b0, 32'h8400_0010, 1'b1, 12, 13));
        tbl.push_back(mk(3'd1, 32'h0,        32'h0,        32'h7C00_0000, 26'h0,      1'b0, 32'h0000_0011, 1'b1, 13, 14));
        tbl.push_back(mk(3'd1, 32'h0,        32'h0,        32'd5,        26'h0,       1'b1, 32'h0000_0011, 1'b0, 13, 14));
        tbl.push_back(mk(3'd0, 32'h0,        32'h0,        32'h0,        26'h0,       1'b0, 32'h0000_0012, 1'b0, 13, 14));

        reset_n = 1'b0;
        drive(3'd0, 32'h0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        cycle();
        chk("reset_pc", 64'(pc_o[0]), 64'h0);
        chk("reset_valid", 64'(valid_o[0]), 64'h0);
        chk("reset_flush", 64'(flush_o[0]), 64'h0);
        chk("reset_halted", 64'(halted_o[0]), 64'h0);
        chk("reset_counts", {32'(bc_o[0]), 32'(tc_o[0])}, 64'h0);

        reset_n = 1'b1;
        cycle();
        chk("boot_pc", 64'(pc_o[0]), 64'h0);
        chk("boot_valid", 64'(valid_o[0]), 64'h1);

        foreach (tbl[k]) begin
            drive(tbl[k].op, tbl[k].rs, tbl[k].rt, tbl[k].im, tbl[k].jt, tbl[k].st, 1'b0);
            cycle();
            chk($sformatf("vec%0d_pc", k),    64'(pc_o[0]),    64'(tbl[k].pc));
            chk($sformatf("vec%0d_flush", k), 64'(flush_o[0]), 64'(tbl[k].fl));
            chk($sformatf("vec%0d_bc", k),    64'(bc_o[0]),    64'(tbl[k].bc));
            chk($sformatf("vec%0d_tc", k),    64'(tc_o[0]),    64'(tbl[k].tc));
        end

        // Taken BEQ held off by three stall cycles, then redirects.
        drive(3'd1, 32'h5, 32'h5, 32'd8, 26'h0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("stall_pc", 64'(pc_o[0]), 64'h12);
            chk("stall_flush", 64'(flush_o[0]), 64'h0);
            chk("stall_counts", {32'(bc_o[0]), 32'(tc_o[0])}, {32'd13, 32'd14});
        end
        stall = 1'b0;
        cycle();
        chk("unstall_pc", 64'(pc_o[0]), 64'h1B);
        chk("unstall_flush", 64'(flush_o[0]), 64'h1);
        chk("unstall_counts", {32'(bc_o[0]), 32'(tc_o[0])}, {32'd14, 32'd15});
        drive(3'd0, 32'h0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        cycle();
        chk("after_redirect_pc", 64'(pc_o[0]), 64'h1C);
        chk("after_redirect_flush", 64'(flush_o[0]), 64'h0);

        // halt_req under stall is ignored.
        drive(3'd0, 32'h0, 32'h0, 32'h0, 26'h0, 1'b1, 1'b1);
        cycle();
        chk("halt_stalled", 64'(halted_o[0]), 64'h0);
        chk("halt_stalled_pc", 64'(pc_o[0]), 64'h1C);

        // Taken BNE retiring together with halt_req.
        drive(3'd2, 32'h1, 32'h2, 32'd4, 26'h0, 1'b0, 1'b1);
        cycle();
        chk("halt_pc", 64'(pc_o[0]), 64'h21);
        chk("halt_flush", 64'(flush_o[0]), 64'h1);
        chk("halt_halted", 64'(halted_o[0]), 64'h1);
        chk("halt_valid", 64'(valid_o[0]), 64'h0);
        chk("halt_counts", {32'(bc_o[0]), 32'(tc_o[0])}, {32'd15, 32'd16});
        drive(3'd1, 32'h0, 32'h0, 32'd9, 26'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("halted_pc", 64'(pc_o[0]), 64'h21);
            chk("halted_flush", 64'(flush_o[0]), 64'h0);
            chk("halted_tc", 64'(tc_o[0]), 64'd16);
        end

        reset_n = 1'b0;
        cycle();
        chk("rst2_pc", 64'(pc_o[0]), 64'h0);
        chk("rst2_halted", 64'(halted_o[0]), 64'h0);
        chk("rst2_counts", {32'(bc_o[0]), 32'(tc_o[0])}, 64'h0);
        reset_n = 1'b1;
        drive(3'd0, 32'h0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        cycle();
        chk("rst2_boot_valid", 64'(valid_o[0]), 64'h1);

        // Byte-addressed instance: J and JR targets.
        drive(3'd7, 32'h10, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        cycle();
        chk("step4_jr_pc", 64'(pc_o[1]), 64'h10);
        drive(3'd6, 32'h0, 32'h0, 32'h0, 26'h40, 1'b0, 1'b0);
        cycle();
        chk("step4_j_pc", 64'(pc_o[1]), 64'h100);
        chk("step4_j_flush", 64'(flush_o[1]), 64'h1);
        drive(3'd7, 32'h2000, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
        cycle();
        chk("step4_jr2_pc", 64'(pc_o[1]), 64'h2000);

        // Saturation on the 2-bit counter instance.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        drive(3'd2, 32'h1, 32'h2, 32'd1, 26'h0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) cycle();
        chk("sat_tc", 64'(tc_c), 64'd3);
        chk("sat_bc", 64'(bc_c), 64'd3);
        chk("nosat_tc", 64'(tc_o[0]), 64'd4);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int sv;
            reset_n  = ($urandom_range(0, 29) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            halt_req = ($urandom_range(0, 39) == 0);
            br_op    = 3'($urandom_range(0, 7));
            rs_data  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            rt_data  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            sv       = int'($urandom_range(0, 16)) - 8;
            imm      = ($urandom_range(0, 3) != 0) ? 32'(sv) : 32'($urandom);
            jtarget  = 26'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
